// File: rtl/dfr_reservoir_param.sv
// Delay-feedback reservoir: input plus scaled tail feedback, tent or linear nonlinearity, N-deep node line.
// IDLE: wait for din | NONLIN: apply f(sum) | SHIFT: push nl into node line, pulse dout_valid
module dfr_reservoir_param #(
  parameter int NUM_VIRTUAL_NODES = 10,
  parameter int DATA_WIDTH        = 16,
  parameter int INPUT_SHIFT       = 0,
  parameter int FEEDBACK_SHIFT    = 1,
  parameter int KNEE              = 2**(DATA_WIDTH-2)
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 clr,
  input  logic                                 mode,
  input  logic [DATA_WIDTH-1:0]                din,
  input  logic                                 din_valid,
  output logic                                 din_ready,
  output logic [DATA_WIDTH-1:0]                dout,
  output logic                                 dout_valid,
  output logic                                 frame_done,
  input  logic [$clog2(NUM_VIRTUAL_NODES)-1:0] node_sel,
  output logic [DATA_WIDTH-1:0]                node_dout
);

  localparam int N     = NUM_VIRTUAL_NODES;
  localparam int DW    = DATA_WIDTH;
  localparam int SEL_W = $clog2(NUM_VIRTUAL_NODES);
  localparam logic [DW:0]      KNEE_X  = (DW+1)'(KNEE);
  localparam logic [DW:0]      KNEE2_X = (DW+1)'(2*KNEE);
  localparam logic [SEL_W-1:0] LAST    = SEL_W'(N-1);

  typedef enum logic [1:0] {IDLE, NONLIN, SHIFT} state_t;

  state_t          state, state_d;
  logic            accept, do_nl, do_shift;
  logic [DW-1:0]   nodes [N];
  logic [DW-1:0]   sum, nl, sum_d, nl_d;
  logic            mode_q;
  logic [SEL_W-1:0] cnt;
  logic [DW:0]     sum_raw, sum_x;

  always_comb begin
    state_d   = state;
    din_ready = 1'b0;
    accept    = 1'b0;
    do_nl     = 1'b0;
    do_shift  = 1'b0;
    case (state)
      IDLE: begin
        din_ready = 1'b1;
        if (din_valid) begin
          accept  = 1'b1;
          state_d = NONLIN;
        end
      end
      NONLIN: begin
        do_nl   = 1'b1;
        state_d = SHIFT;
      end
      SHIFT: begin
        do_shift = 1'b1;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // clear wins over everything, including a sample offered in the same cycle
    if (clr) begin
      state_d   = IDLE;
      din_ready = 1'b0;
      accept    = 1'b0;
      do_nl     = 1'b0;
      do_shift  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) state <= IDLE;
    else      state <= state_d;
  end

  always_comb begin
    sum_raw = {1'b0, din >> INPUT_SHIFT} + {1'b0, nodes[N-1] >> FEEDBACK_SHIFT};
    sum_d   = sum_raw[DW] ? '1 : sum_raw[DW-1:0];
  end

  always_comb begin
    sum_x = {1'b0, sum};
    nl_d  = '0;
    if (mode_q || (sum_x < KNEE_X)) nl_d = sum;
    else if (sum_x < KNEE2_X)        nl_d = DW'(KNEE2_X - sum_x);
  end

  always_ff @(posedge clk) begin
    if (!rst || clr) begin
      for (int k = 0; k < N; k++) nodes[k] <= '0;
      sum        <= '0;
      nl         <= '0;
      mode_q     <= 1'b0;
      cnt        <= '0;
      dout_valid <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      dout_valid <= do_shift;
      frame_done <= do_shift && (cnt == LAST);
      if (accept) begin
        sum    <= sum_d;
        mode_q <= mode;
      end
      if (do_nl) nl <= nl_d;
      if (do_shift) begin
        for (int k = N-1; k > 0; k--) nodes[k] <= nodes[k-1];
        nodes[0] <= nl;
        cnt      <= (cnt == LAST) ? '0 : cnt + 1'b1;
      end
    end
  end

  assign dout = nodes[0];

  always_comb begin
    node_dout = '0;
    if (32'(node_sel) < N) node_dout = nodes[node_sel];
  end

endmodule

// File: tb/tb_dfr_reservoir_param.sv
// Directed and randomized checks of dfr_reservoir_param against an arithmetic reference model.
module tb_dfr_reservoir_param;
  localparam int N    = 4;
  localparam int DW   = 16;
  localparam int IS   = 0;
  localparam int FS   = 1;
  localparam int K    = 'h4000;
  localparam int MAXV = (1 << DW) - 1;

  logic          clk = 0;
  logic          rst = 0;
  logic          clr = 0;
  logic          mode = 0;
  logic [DW-1:0] din = '0;
  logic          din_valid = 0;
  logic          din_ready;
  logic [DW-1:0] dout;
  logic          dout_valid;
  logic          frame_done;
  logic [1:0]    node_sel = '0;
  logic [DW-1:0] node_dout;

  int n_checks = 0;
  int n_errors = 0;
  int m_nodes [N];
  int m_cnt;
  int last_out;

  dfr_reservoir_param #(
    .NUM_VIRTUAL_NODES(N), .DATA_WIDTH(DW), .INPUT_SHIFT(IS),
    .FEEDBACK_SHIFT(FS), .KNEE(K)
  ) dut (
    .clk(clk), .rst(rst), .clr(clr), .mode(mode), .din(din),
    .din_valid(din_valid), .din_ready(din_ready), .dout(dout),
    .dout_valid(dout_valid), .frame_done(frame_done),
    .node_sel(node_sel), .node_dout(node_dout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_clear();
    for (int k = 0; k < N; k++) m_nodes[k] = 0;
    m_cnt = 0;
  endtask

  // reservoir equation from first principles: saturating add, then tent or identity
  task automatic model_step(input int d, input bit m, output int v, output bit fr);
    int s;
    s = (d >> IS) + (m_nodes[N-1] >> FS);
    if (s > MAXV) s = MAXV;
    if (m)               v = s;
    else if (s < K)      v = s;
    else if (s < 2 * K)  v = 2 * K - s;
    else                 v = 0;
    for (int k = N-1; k > 0; k--) m_nodes[k] = m_nodes[k-1];
    m_nodes[0] = v;
    fr = (m_cnt == N-1);
    m_cnt = fr ? 0 : m_cnt + 1;
  endtask

  task automatic do_reset();
    rst = 0; clr = 0; din_valid = 0;
    repeat (3) @(posedge clk);
    #1 rst = 1;
    model_clear();
  endtask

  task automatic send(input logic [DW-1:0] d, input logic m, input string tag);
    int  v;
    bit  fr;
    bool_wait: begin
      int budget;
      budget = 0;
      din = d; mode = m; din_valid = 1;
      while (!din_ready && budget < 20) begin
        tick();
        budget++;
      end
      if (!din_ready) chk({tag, "_ready_timeout"}, 0, 1);
    end
    model_step(int'(d), m, v, fr);
    tick();
    din_valid = 0;
    mode = ~m;
    din = ~d;
    chk({tag, "_ready_t1"}, din_ready, 0);
    tick();
    chk({tag, "_valid_t2"}, dout_valid, 0);
    tick();
    chk({tag, "_valid_t3"}, dout_valid, 1);
    chk({tag, "_dout"}, dout, v);
    chk({tag, "_frame"}, frame_done, fr);
    chk({tag, "_ready_t3"}, din_ready, 1);
    last_out = v;
  endtask

  initial begin
    int acc_cyc [$];
    int acc_val [$];
    int v;
    bit fr;

    // 1. reset defaults
    do_reset();
    chk("rst_dout", dout, 0);
    chk("rst_dout_valid", dout_valid, 0);
    chk("rst_frame_done", frame_done, 0);
    chk("rst_din_ready", din_ready, 1);
    for (int s = 0; s < N; s++) begin
      node_sel = 2'(s);
      #1 chk("rst_node_dout", node_dout, 0);
    end
    tick();

    // 2. linear region and feedback
    for (int i = 0; i < 5; i++) send(16'h1000, 0, "lin");
    chk("lin_fb_const", dout, 16'h1800);

    // 3. tent fold, then bypass
    do_reset();
    send(16'h6000, 0, "tent_a"); chk("tent_a_const", dout, 16'h2000);
    send(16'h9000, 0, "tent_b"); chk("tent_b_const", dout, 16'h0000);
    do_reset();
    send(16'h6000, 1, "byp_a"); chk("byp_a_const", dout, 16'h6000);
    send(16'h9000, 1, "byp_b"); chk("byp_b_const", dout, 16'h9000);

    // 4. saturation
    do_reset();
    for (int i = 0; i < 4; i++) send(16'hFFFF, 1, "sat_pre");
    send(16'hFFFF, 1, "sat_byp"); chk("sat_byp_const", dout, 16'hFFFF);
    do_reset();
    for (int i = 0; i < 4; i++) send(16'hFFFF, 1, "sat_pre2");
    send(16'hFFFF, 0, "sat_tent"); chk("sat_tent_const", dout, 16'h0000);

    // 5. held din_valid, incrementing din
    do_reset();
    din = 16'($urandom_range(0, 'h2000));
    mode = 1'($urandom);
    din_valid = 1;
    for (int c = 0; c < 12; c++) begin
      chk("hs_ready_pattern", din_ready, (c % 3 == 0));
      chk("hs_valid_pattern", dout_valid, (c % 3 == 0) && (c >= 3));
      if (din_ready) begin
        acc_cyc.push_back(c);
        acc_val.push_back(int'(din));
        model_step(int'(din), mode, v, fr);
      end
      tick();
      din = din + 1'b1;
    end
    din_valid = 0;
    chk("hs_accept_count", acc_cyc.size(), 4);
    for (int i = 1; i < acc_cyc.size(); i++)
      chk("hs_spacing", acc_cyc[i] - acc_cyc[i-1], 3);
    chk("hs_last_valid", dout_valid, 1);
    for (int s = 0; s < N; s++) begin
      node_sel = 2'(s);
      #1;
      chk("hs_node_model", node_dout, m_nodes[s]);
      if (acc_val.size() == 4) chk("hs_node_input", node_dout, acc_val[3 - s]);
    end
    tick();

    // 6. clear mid-flight
    do_reset();
    send(16'($urandom_range(0, 'h3FFF)), 0, "clr_pre");
    send(16'($urandom_range(0, 'h3FFF)), 0, "clr_pre");
    din = 16'h1234; mode = 0; din_valid = 1;
    tick();
    din_valid = 0;
    chk("clr_in_nonlin", din_ready, 0);
    clr = 1;
    tick();
    clr = 0;
    model_clear();
    for (int c = 0; c < 4; c++) begin
      chk("clr_no_valid", dout_valid, 0);
      tick();
    end
    for (int s = 0; s < N; s++) begin
      node_sel = 2'(s);
      #1 chk("clr_node_zero", node_dout, 0);
    end
    tick();
    for (int i = 0; i < 4; i++) send(16'($urandom_range(0, 'hFFFF)), 1'($urandom), "clr_post");

    // randomized soak against the model
    do_reset();
    for (int i = 0; i < 30; i++) send(16'($urandom), 1'($urandom), "rand");
    for (int s = 0; s < N; s++) begin
      node_sel = 2'(s);
      #1 chk("rand_node", node_dout, m_nodes[s]);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
